bus_dma: RTL and testbench

- Memory-to-memory word-copy engine and the second initiator on the 32-bit system bus.
- The CPU programs it as a peripheral through a slave register port, in the same style as the Timer and DigitalPort.
- It then requests the bus from the top-level arbiter and drives its own address, write-data and write-enable lines.
- Read path matches the BRAM-backed memories: data appears one cycle after the address is presented.

---
 rtl/bus_dma.sv | 167 ++++++++++++++++
 tb/tb_bus_dma.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma.sv
// Memory-to-memory word-copy DMA engine: CPU-programmed through a slave register port,
// copies LEN words from SRC to DST as a second bus initiator, releasing the bus every MAX_BURST words.
module bus_dma #(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfgChipSelect,
  input  logic        cfgWrite,
  input  logic [1:0]  cfgAddr,
  input  logic [31:0] cfgDataIn,
  output logic [31:0] cfgDataOut,
  output logic        busRequest,
  input  logic        busGrant,
  output logic [31:0] busAddress,
  output logic [31:0] busDataOut,
  input  logic [31:0] busDataIn,
  output logic        busWriteEnable,
  output logic        irq
);

  localparam logic [7:0] LP_BURST = 8'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_RD, S_CAP, S_WR, S_REL, S_DONE
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_src, r_dst, r_data;
  logic [31:0] w_src_nxt, w_dst_nxt, w_data_nxt;
  logic [15:0] r_len, w_len_nxt;
  logic [7:0]  r_burst, w_burst_nxt;
  logic        r_done, r_aborted, w_done_nxt, w_aborted_nxt, w_irq_nxt;
  logic        r_req, r_we, r_irq;
  logic [31:0] r_addr, r_dout;
  logic        w_busy, w_cfg_wr, w_start, w_abort;

  assign w_busy   = r_state inside {S_REQ, S_RD, S_CAP, S_WR, S_REL};
  assign w_cfg_wr = cfgChipSelect & cfgWrite;
  assign w_abort  = w_cfg_wr && (cfgAddr == 2'd3) && cfgDataIn[1];
  assign w_start  = w_cfg_wr && (cfgAddr == 2'd3) && cfgDataIn[0] && !cfgDataIn[1];

  always_comb begin
    w_state_nxt   = r_state;
    w_src_nxt     = r_src;
    w_dst_nxt     = r_dst;
    w_len_nxt     = r_len;
    w_burst_nxt   = r_burst;
    w_data_nxt    = r_data;
    w_done_nxt    = r_done;
    w_aborted_nxt = r_aborted;
    w_irq_nxt     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        if (w_cfg_wr) begin
          case (cfgAddr)
            2'd0:    w_src_nxt = {cfgDataIn[31:2], 2'b00};
            2'd1:    w_dst_nxt = {cfgDataIn[31:2], 2'b00};
            2'd2:    w_len_nxt = cfgDataIn[15:0];
            default: ;
          endcase
        end
        if (w_start) begin
          w_done_nxt    = 1'b0;
          w_aborted_nxt = 1'b0;
          w_burst_nxt   = '0;
          if (r_len == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_irq_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: if (busGrant) w_state_nxt = S_RD;
      S_RD:  w_state_nxt = S_CAP;
      S_CAP: begin
        w_state_nxt = S_WR;
        w_data_nxt  = busDataIn;
      end
      S_WR: begin
        w_src_nxt   = r_src + 32'd4;
        w_dst_nxt   = r_dst + 32'd4;
        w_len_nxt   = r_len - 16'd1;
        w_burst_nxt = r_burst + 8'd1;
        if (r_len == 16'd1) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
          w_irq_nxt   = 1'b1;
        end else if (w_abort) begin
          w_state_nxt   = S_IDLE;
          w_aborted_nxt = 1'b1;
          w_irq_nxt     = 1'b1;
        end else if (r_burst + 8'd1 == LP_BURST) begin
          w_state_nxt = S_REL;
          w_burst_nxt = '0;
        end else begin
          w_state_nxt = S_RD;
        end
      end
      S_REL:   w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides any non-write state's normal progression; WR handles it after its write lands.
    if (w_abort && (r_state inside {S_REQ, S_RD, S_CAP, S_REL})) begin
      w_state_nxt   = S_IDLE;
      w_aborted_nxt = 1'b1;
      w_irq_nxt     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_burst   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_irq     <= 1'b0;
      r_addr    <= '0;
      r_dout    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_src     <= w_src_nxt;
      r_dst     <= w_dst_nxt;
      r_len     <= w_len_nxt;
      r_burst   <= w_burst_nxt;
      r_data    <= w_data_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      r_irq     <= w_irq_nxt;
      // Bus outputs are registered from the next state so they line up with the state they describe.
      r_req     <= w_state_nxt inside {S_REQ, S_RD, S_CAP, S_WR};
      r_we      <= (w_state_nxt == S_WR);
      r_dout    <= (w_state_nxt == S_WR) ? w_data_nxt : '0;
      if (w_state_nxt inside {S_RD, S_CAP})
        r_addr <= w_src_nxt;
      else if (w_state_nxt == S_WR)
        r_addr <= w_dst_nxt;
      else
        r_addr <= '0;
    end
  end

  always_comb begin
    case (cfgAddr)
      2'd0:    cfgDataOut = r_src;
      2'd1:    cfgDataOut = r_dst;
      2'd2:    cfgDataOut = {16'b0, r_len};
      default: cfgDataOut = {w_busy, r_done, r_aborted, 13'b0, r_len};
    endcase
  end

  assign busRequest     = r_req;
  assign busAddress     = r_addr;
  assign busDataOut     = r_dout;
  assign busWriteEnable = r_we;
  assign irq            = r_irq;

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: a bus-slave memory, a simple arbiter and an expected-write
// scoreboard checked every cycle, plus hand-computed timing and register expectations.
module tb_bus_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfgChipSelect = 1'b0;
  logic        cfgWrite = 1'b0;
  logic [1:0]  cfgAddr = 2'd0;
  logic [31:0] cfgDataIn = '0;
  logic [31:0] cfgDataOut;
  logic        busRequest;
  logic        busGrant;
  logic [31:0] busAddress;
  logic [31:0] busDataOut;
  logic [31:0] busDataIn = '0;
  logic        busWriteEnable;
  logic        irq;

  bus_dma #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cfgChipSelect(cfgChipSelect), .cfgWrite(cfgWrite), .cfgAddr(cfgAddr),
    .cfgDataIn(cfgDataIn), .cfgDataOut(cfgDataOut),
    .busRequest(busRequest), .busGrant(busGrant), .busAddress(busAddress),
    .busDataOut(busDataOut), .busDataIn(busDataIn),
    .busWriteEnable(busWriteEnable), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned t0 = 0;
  logic [31:0] mem [int unsigned];
  wr_t         exp_q[$];
  int unsigned wr_cyc_log[$];
  logic [31:0] wr_addr_log[$];
  int unsigned gap_log[$];
  int          irq_cnt = 0;
  int unsigned irq_cyc = 0;
  int unsigned req_cnt = 0;
  int unsigned low_run = 0;
  logic        prev_req = 1'b0;
  logic        prev_irq = 1'b0;
  bit          tie_grant = 1'b1;
  int unsigned grant_delay = 0;
  logic [31:0] v;

  assign busGrant = tie_grant ? 1'b1 : (busRequest && (req_cnt >= grant_delay));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Unwritten words read back a fixed pattern derived from their word address.
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned k;
    k = {2'b00, a[31:2]};
    if (mem.exists(k)) return mem[k];
    return 32'hC0DE0000 ^ {2'b00, a[31:2]};
  endfunction

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    req_cnt   <= busRequest ? req_cnt + 1 : 0;
    busDataIn <= mem_rd(busAddress);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (!busRequest) begin
        check("idle_addr", busAddress, 32'h0);
        check("idle_we", 32'(busWriteEnable), 32'h0);
      end
      if (busWriteEnable) begin
        wr_cyc_log.push_back(cyc);
        wr_addr_log.push_back(busAddress);
        mem[{2'b00, busAddress[31:2]}] = busDataOut;
        check("write_was_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", busAddress, e.a);
          check("wr_data", busDataOut, e.d);
        end
      end
      if (irq) begin
        irq_cnt++;
        irq_cyc = cyc;
        check("irq_one_cycle", 32'(prev_irq), 32'h0);
      end
      if (busRequest && !prev_req) gap_log.push_back(low_run);
      low_run = busRequest ? 0 : low_run + 1;
    end
    prev_irq = irq;
    prev_req = busRequest;
  end

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cfgChipSelect = 1'b1; cfgWrite = 1'b1; cfgAddr = a; cfgDataIn = d;
    t0 = cyc;
    @(negedge clk);
    cfgChipSelect = 1'b0; cfgWrite = 1'b0; cfgDataIn = '0;
  endtask

  task automatic cfg_rd(input logic [1:0] a, output logic [31:0] d);
    cfgAddr = a;
    #1 d = cfgDataOut;
  endtask

  // Program a transfer, queue the writes expected to land, then START.
  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                        input int unsigned n_land);
    cfg_wr(2'd0, s);
    cfg_wr(2'd1, d);
    cfg_wr(2'd2, {16'b0, n});
    for (int unsigned i = 0; i < n_land; i++) begin
      wr_t e;
      e.a = d + 32'(4 * i);
      e.d = mem_rd(s + 32'(4 * i));
      exp_q.push_back(e);
    end
    cfg_wr(2'd3, 32'h1);
  endtask

  task automatic wait_irq(input int n0, input int unsigned budget, input string name);
    int unsigned k;
    k = 0;
    while (irq_cnt == n0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    #1;
    check(name, 32'(irq_cnt - n0), 32'h1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int          n0;
    int unsigned w0, r0, k;
    logic [31:0] ram_exp [4];
    bit          found;
    ram_exp[0] = 32'hC0DE0040; ram_exp[1] = 32'hC0DE0041;
    ram_exp[2] = 32'hC0DE0042; ram_exp[3] = 32'hC0DE0043;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", 32'(busRequest), 32'h0);
    check("rst_addr", busAddress, 32'h0);
    check("rst_dout", busDataOut, 32'h0);
    check("rst_we", 32'(busWriteEnable), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_rd(2'(i), v);
      check("rst_reg", v, 32'h0);
    end

    // Plain copy with grant tied high
    n0 = irq_cnt; w0 = wr_cyc_log.size();
    launch(32'h00000100, 32'h00010000, 16'd4, 4);
    wait_irq(n0, 40, "copy_irq");
    check("copy_nwrites", wr_cyc_log.size() - w0, 32'd4);
    if (wr_cyc_log.size() - w0 == 4)
      for (int unsigned i = 0; i < 4; i++)
        check("copy_wr_cycle", wr_cyc_log[w0 + i] - t0, 4 + 3 * i);
    check("copy_irq_cycle", irq_cyc - t0, 32'd14);
    for (int unsigned i = 0; i < 4; i++)
      check("copy_ram", mem_rd(32'h00010000 + 4 * i), ram_exp[i]);
    cfg_rd(2'd3, v); check("copy_status", v, 32'h40000000);
    cfg_rd(2'd0, v); check("copy_src", v, 32'h00000110);
    cfg_rd(2'd1, v); check("copy_dst", v, 32'h00010010);
    check("copy_pending", exp_q.size(), 32'd0);

    // Burst split with grant withheld 3 cycles per request; SRC write while busy is ignored
    tie_grant = 1'b0; grant_delay = 3;
    n0 = irq_cnt; r0 = gap_log.size();
    launch(32'h00000400, 32'h00030000, 16'd9, 9);
    cfg_wr(2'd0, 32'hDEAD0000);
    wait_irq(n0, 300, "burst_irq");
    check("burst_requests", gap_log.size() - r0, 32'd1 + (9 - 1) / 4);
    if (gap_log.size() - r0 == 3)
      for (int unsigned j = 1; j < 3; j++) check("burst_release_len", gap_log[r0 + j], 32'd1);
    cfg_rd(2'd0, v); check("burst_src", v, 32'h00000400 + 4 * 9);
    cfg_rd(2'd3, v); check("burst_status", v, 32'h40000000);
    check("burst_pending", exp_q.size(), 32'd0);

    // Abort during the write of the second of four words
    tie_grant = 1'b1;
    n0 = irq_cnt; w0 = wr_cyc_log.size();
    launch(32'h00000200, 32'h00020000, 16'd4, 2);
    found = 1'b0; k = 0;
    while (!found && k < 30) begin
      @(negedge clk);
      k++;
      if (busWriteEnable && busAddress == 32'h00020004) found = 1'b1;
    end
    check("abort_wr_seen", 32'(found), 32'h1);
    cfgChipSelect = 1'b1; cfgWrite = 1'b1; cfgAddr = 2'd3; cfgDataIn = 32'h2;
    @(negedge clk);
    cfgChipSelect = 1'b0; cfgWrite = 1'b0; cfgDataIn = '0;
    wait_irq(n0, 20, "abort_irq");
    repeat (10) @(negedge clk);
    check("abort_nwrites", wr_cyc_log.size() - w0, 32'd2);
    cfg_rd(2'd3, v); check("abort_status", v, 32'h20000002);
    cfg_rd(2'd0, v); check("abort_src", v, 32'h00000208);
    cfg_rd(2'd1, v); check("abort_dst", v, 32'h00020008);
    check("abort_pending", exp_q.size(), 32'd0);

    // Abort while still waiting for grant
    tie_grant = 1'b0; grant_delay = 3;
    n0 = irq_cnt; w0 = wr_cyc_log.size();
    launch(32'h00000500, 32'h00040000, 16'd3, 0);
    cfg_wr(2'd3, 32'h2);
    wait_irq(n0, 20, "abort_req_irq");
    repeat (6) @(negedge clk);
    check("abort_req_nwrites", wr_cyc_log.size() - w0, 32'd0);
    cfg_rd(2'd3, v); check("abort_req_status", v, 32'h20000003);

    // START and ABORT together: nothing starts
    tie_grant = 1'b1;
    n0 = irq_cnt; r0 = gap_log.size();
    cfg_wr(2'd2, 32'd5);
    cfg_wr(2'd3, 32'h3);
    repeat (6) @(negedge clk);
    check("startabort_irq", 32'(irq_cnt - n0), 32'h0);
    check("startabort_req", gap_log.size() - r0, 32'd0);
    cfg_rd(2'd3, v); check("startabort_status", v, 32'h20000005);

    // START with LEN=0
    n0 = irq_cnt; r0 = gap_log.size();
    cfg_wr(2'd2, 32'd0);
    cfg_wr(2'd3, 32'h1);
    wait_irq(n0, 10, "len0_irq");
    check("len0_irq_cycle", irq_cyc - t0, 32'd1);
    repeat (4) @(negedge clk);
    check("len0_no_req", gap_log.size() - r0, 32'd0);
    cfg_rd(2'd3, v); check("len0_status", v, 32'h40000000);

    // Destination address wraps past the top of memory
    n0 = irq_cnt; w0 = wr_cyc_log.size();
    launch(32'h00000300, 32'hFFFFFFFC, 16'd2, 2);
    wait_irq(n0, 30, "wrap_irq");
    check("wrap_nwrites", wr_addr_log.size() - w0, 32'd2);
    if (wr_addr_log.size() - w0 == 2) begin
      check("wrap_addr0", wr_addr_log[w0], 32'hFFFFFFFC);
      check("wrap_addr1", wr_addr_log[w0 + 1], 32'h00000000);
    end
    cfg_rd(2'd1, v); check("wrap_dst", v, 32'h00000004);
    check("wrap_pending", exp_q.size(), 32'd0);

    // Synchronous reset during CAP
    n0 = irq_cnt; w0 = wr_cyc_log.size(); r0 = gap_log.size();
    launch(32'h00000600, 32'h00050000, 16'd4, 0);
    found = 1'b0; k = 0;
    while (!found && k < 30) begin
      @(negedge clk);
      k++;
      if (busRequest && !busWriteEnable && busAddress == 32'h00000600) begin
        @(negedge clk);
        k++;
        if (busRequest && !busWriteEnable && busAddress == 32'h00000600) found = 1'b1;
      end
    end
    check("rstcap_seen", 32'(found), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("rstcap_req", 32'(busRequest), 32'h0);
    check("rstcap_addr", busAddress, 32'h0);
    check("rstcap_dout", busDataOut, 32'h0);
    check("rstcap_we", 32'(busWriteEnable), 32'h0);
    check("rstcap_irq", 32'(irq), 32'h0);
    cfg_rd(2'd3, v); check("rstcap_status", v, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rstcap_nwrites", wr_cyc_log.size() - w0, 32'd0);
    check("rstcap_noirq", 32'(irq_cnt - n0), 32'h0);
    check("rstcap_no_rereq", gap_log.size() - r0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
